// File: rtl/temp_frame_bcd.sv
// temp_frame_bcd: multi-channel sensor frame parser with sequential BCD converter.
// Optional inter-byte timeout enabled by defining TEMP_FRAME_TIMEOUT_EN.
module temp_frame_bcd #(
    parameter int          DATA_W      = 16,
    parameter int          DIGITS      = 5,
    parameter int          CH_NUM      = 4,
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int          TIMEOUT_CYC = 2400000,
    localparam int         SEL_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid,
    input  logic [SEL_W-1:0]      ch_sel,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  bcd_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int NBYTES = (DATA_W + 7) / 8;
    localparam int DW8    = NBYTES * 8;
    // Enough internal digits for any DATA_W-bit value, so saturation is detectable
    localparam int NI     = DATA_W / 3 + 1;
    localparam int ND     = (NI > DIGITS) ? NI : DIGITS;
    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [7:0] CH_LIM = 8'(CH_NUM);

    typedef enum logic [1:0] {S_IDLE, S_CH, S_DATA, S_SUM} state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic                w_accept;
    logic                w_reject;
    logic                w_timeout;
    logic [7:0]          r_ch;
    logic [7:0]          r_sum;
    logic [DW8-1:0]      r_data;
    logic [1:0]          r_bcnt;
    logic                r_ferr;
    logic [DATA_W-1:0]   r_chan [CH_NUM];

    logic [SEL_W-1:0]    r_prev_sel;
    logic                w_trig;
    logic [DATA_W-1:0]   w_sel_val;
    logic                r_start;
    logic                r_busy;
    logic                r_pend;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_bin;
    logic [4*ND-1:0]     r_bcd;
    logic [4*ND-1:0]     w_adj;
    logic [4*ND-1:0]     w_bcd_nx;
    logic                w_last;
    logic                w_sat;
    logic [4*DIGITS-1:0] w_out;
    logic [4*DIGITS-1:0] r_bcd_o;
    logic                r_valid;

`ifdef TEMP_FRAME_TIMEOUT_EN
    logic [31:0]         r_to_cnt;

    // Inter-byte idle counter, only meaningful while a frame is open
    always_ff @(posedge clk) begin
        if (rst || r_state == S_IDLE || byte_valid) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
    end

    assign w_timeout = (r_state != S_IDLE) && !byte_valid &&
                       (r_to_cnt == 32'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Parser state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Parser next state and frame verdict
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_reject   = 1'b0;
        if (byte_valid) begin
            unique case (r_state)
                S_IDLE: if (byte_i == HEADER) w_state_nx = S_CH;
                S_CH:   w_state_nx = S_DATA;
                S_DATA: if (r_bcnt == 2'(NBYTES - 1)) w_state_nx = S_SUM;
                S_SUM: begin
                    w_state_nx = S_IDLE;
                    if (byte_i == r_sum && r_ch < CH_LIM) w_accept = 1'b1;
                    else                                  w_reject = 1'b1;
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
        if (w_timeout) w_state_nx = S_IDLE;
    end

    // Frame fields, checksum accumulation and channel register writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch   <= '0;
            r_sum  <= '0;
            r_data <= '0;
            r_bcnt <= '0;
            r_ferr <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) r_chan[i] <= '0;
        end else begin
            r_ferr <= w_reject | w_timeout;
            if (byte_valid && r_state == S_CH) begin
                r_ch   <= byte_i;
                r_sum  <= byte_i;
                r_bcnt <= '0;
            end
            if (byte_valid && r_state == S_DATA) begin
                r_data <= (r_data << 8) | DW8'(byte_i);
                r_sum  <= r_sum + byte_i;
                r_bcnt <= r_bcnt + 2'd1;
            end
            if (w_accept) begin
                for (int i = 0; i < CH_NUM; i++) begin
                    if (r_ch == 8'(i)) r_chan[i] <= r_data[DATA_W-1:0];
                end
            end
        end
    end

    // Selected channel mux; out-of-range selections read as zero
    always_comb begin
        w_sel_val = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (ch_sel == SEL_W'(i)) w_sel_val = r_chan[i];
        end
    end

    assign w_trig = (w_accept && r_ch == 8'(ch_sel)) || (ch_sel != r_prev_sel);

    // Double-dabble step: add 3 to digits >= 5, then shift one bit in
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < ND; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
        w_bcd_nx = {w_adj[4*ND-2:0], r_bin[DATA_W-1]};
    end

    // Saturate to all nines when the value exceeds the output digit count
    always_comb begin
        w_sat = 1'b0;
        for (int i = DIGITS; i < ND; i++) begin
            if (w_bcd_nx[4*i +: 4] != 4'd0) w_sat = 1'b1;
        end
        w_out = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_out[4*i +: 4] = w_sat ? 4'd9 : w_bcd_nx[4*i +: 4];
        end
    end

    assign w_last = r_busy && (r_cnt == CNT_W'(DATA_W - 1));

    // Conversion engine sequencing with a single merged pending request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_sel <= ch_sel;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_pend     <= 1'b0;
            r_cnt      <= '0;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_bcd_o    <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_prev_sel <= ch_sel;
            r_valid    <= 1'b0;
            if (r_start) begin
                r_start <= 1'b0;
                r_busy  <= 1'b1;
                r_cnt   <= '0;
                r_bin   <= w_sel_val;
                r_bcd   <= '0;
            end
            if (r_busy) begin
                r_bin <= r_bin << 1;
                r_bcd <= w_bcd_nx;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_last) begin
                r_busy  <= 1'b0;
                r_bcd_o <= w_out;
                r_valid <= 1'b1;
                r_pend  <= 1'b0;
                if (r_pend || w_trig) r_start <= 1'b1;
            end else if (w_trig) begin
                if (r_start || r_busy) r_pend  <= 1'b1;
                else                   r_start <= 1'b1;
            end
        end
    end

    logic w_unused;
    assign w_unused = (TIMEOUT_CYC != 0) ^ w_adj[4*ND-1] ^ (^r_data);

    assign bcd_o     = r_bcd_o;
    assign bcd_valid = r_valid;
    assign frame_err = r_ferr;
    assign busy      = r_busy;

endmodule

// File: tb/tb_temp_frame_bcd.sv
// Directed bench for temp_frame_bcd: a DIGITS=5 and a DIGITS=4 instance
// share one byte stream and channel select.
module tb_temp_frame_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_i;
    logic        byte_valid;
    logic [1:0]  ch_sel;
    logic [19:0] bcd5;
    logic        v5, err5, busy5;
    logic [15:0] bcd4;
    logic        v4, err4, busy4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    temp_frame_bcd #(.DATA_W(16), .DIGITS(5), .CH_NUM(4), .TIMEOUT_CYC(100)) u_dut (
        .clk(clk), .rst(rst), .byte_i(byte_i), .byte_valid(byte_valid),
        .ch_sel(ch_sel), .bcd_o(bcd5), .bcd_valid(v5),
        .frame_err(err5), .busy(busy5)
    );

    temp_frame_bcd #(.DATA_W(16), .DIGITS(4), .CH_NUM(4), .TIMEOUT_CYC(100)) u_dut4 (
        .clk(clk), .rst(rst), .byte_i(byte_i), .byte_valid(byte_valid),
        .ch_sel(ch_sel), .bcd_o(bcd4), .bcd_valid(v4),
        .frame_err(err4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        byte_i     = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_i     = 8'h00;
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] hi,
                         input logic [7:0] lo, input logic [7:0] s);
        send(8'hA5);
        send(c);
        send(hi);
        send(lo);
        send(s);
    endtask

    // n counts negedges starting at 1 for the current one
    task automatic wait_valid(output int n);
        n = 1;
        while (!v5 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic count_valid(input int cyc, output int cnt);
        cnt = 0;
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            if (v5 || v4) cnt++;
        end
    endtask

    initial begin
        int n;
        int cnt;
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_i     = 8'h00;
        ch_sel     = 2'd1;
        repeat (3) @(negedge clk);
        check("rst_bcd", {12'd0, bcd5}, 32'h0);
        check("rst_valid", {31'd0, v5}, 32'd0);
        check("rst_err", {31'd0, err5}, 32'd0);
        check("rst_busy", {31'd0, busy5}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        frame(8'h01, 8'h09, 8'h1C, 8'h26);
        check("f1_err", {31'd0, err5}, 32'd0);
        @(negedge clk);
        check("f1_busy", {31'd0, busy5}, 32'd1);
        wait_valid(n);
        check("f1_latency", n + 1, 32'd18);
        check("f1_bcd5", {12'd0, bcd5}, 32'h02332);
        check("f1_bcd4", {16'd0, bcd4}, 32'h2332);
        check("f1_busy_drop", {31'd0, busy5}, 32'd0);

        frame(8'h01, 8'h09, 8'h1C, 8'h27);
        check("badsum_err5", {31'd0, err5}, 32'd1);
        check("badsum_err4", {31'd0, err4}, 32'd1);
        @(negedge clk);
        check("badsum_pulse", {31'd0, err5}, 32'd0);
        count_valid(30, cnt);
        check("badsum_noconv", cnt, 32'd0);

        ch_sel = 2'd0;
        @(negedge clk);
        wait_valid(n);
        check("sel0_latency", n, 32'd18);
        check("sel0_bcd", {12'd0, bcd5}, 32'h0);
        ch_sel = 2'd1;
        @(negedge clk);
        wait_valid(n);
        check("ch1_kept", {12'd0, bcd5}, 32'h02332);

        frame(8'h07, 8'h00, 8'h10, 8'h17);
        check("badch_err", {31'd0, err5}, 32'd1);
        ch_sel = 2'd3;
        @(negedge clk);
        wait_valid(n);
        check("badch_ch3", {12'd0, bcd5}, 32'h0);
        ch_sel = 2'd1;
        @(negedge clk);
        wait_valid(n);
        check("badch_ch1", {12'd0, bcd5}, 32'h02332);
        @(negedge clk);

        frame(8'h00, 8'hFF, 8'hFF, 8'hFE);
        check("ch0_err", {31'd0, err5}, 32'd0);
        count_valid(3, cnt);
        check("ch0_noconv", cnt, 32'd0);
        frame(8'h01, 8'h00, 8'h64, 8'h65);
        repeat (3) @(negedge clk);
        check("pend_busy", {31'd0, busy5}, 32'd1);
        ch_sel = 2'd0;
        wait_valid(n);
        check("pend_first_lat", n, 32'd15);
        check("pend_first5", {12'd0, bcd5}, 32'h00100);
        check("pend_first4", {16'd0, bcd4}, 32'h0100);
        check("pend_first_busy", {31'd0, busy5}, 32'd0);
        @(negedge clk);
        check("pend_restart", {31'd0, busy5}, 32'd1);
        wait_valid(n);
        check("pend_second_lat", n, 32'd17);
        check("pend_second5", {12'd0, bcd5}, 32'h65535);
        check("pend_sat4", {16'd0, bcd4}, 32'h9999);
        check("pend_v4", {31'd0, v4}, 32'd1);
        @(negedge clk);

        send(8'hA5);
        send(8'h01);
        send(8'h09);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rstd_bcd5", {12'd0, bcd5}, 32'h0);
        check("rstd_bcd4", {16'd0, bcd4}, 32'h0);
        check("rstd_err", {31'd0, err5}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        frame(8'h00, 8'h12, 8'h34, 8'h46);
        repeat (5) @(negedge clk);
        check("rstc_busy_pre", {31'd0, busy5}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstc_busy", {31'd0, busy5}, 32'd0);
        check("rstc_bcd", {12'd0, bcd5}, 32'h0);
        check("rstc_valid", {31'd0, v5}, 32'd0);
        rst = 1'b0;
        count_valid(30, cnt);
        check("rstc_noconv", cnt, 32'd0);

        frame(8'h00, 8'h30, 8'h39, 8'h69);
        wait_valid(n);
        check("post_lat", n, 32'd18);
        check("post_bcd5", {12'd0, bcd5}, 32'h12345);
        check("post_sat4", {16'd0, bcd4}, 32'h9999);
        @(negedge clk);

        frame(8'h00, 8'hA5, 8'h01, 8'hA6);
        check("hdrdata_err", {31'd0, err5}, 32'd0);
        wait_valid(n);
        check("hdrdata_bcd5", {12'd0, bcd5}, 32'h42241);
        check("hdrdata_bcd4", {16'd0, bcd4}, 32'h9999);
        @(negedge clk);

`ifdef TEMP_FRAME_TIMEOUT_EN
        send(8'hA5);
        send(8'h01);
        n = 1;
        while (!err5 && n < 150) begin
            @(negedge clk);
            n++;
        end
        check("to_delay", n, 32'd101);
        check("to_err", {31'd0, err5}, 32'd1);
        @(negedge clk);
        frame(8'h00, 8'h00, 8'h07, 8'h07);
        check("to_next_err", {31'd0, err5}, 32'd0);
        wait_valid(n);
        check("to_next_bcd", {12'd0, bcd5}, 32'h00007);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=stuck expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
